// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and beat-tag layout for the 3x3 convolution row scheduler.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int PSUM_W = 25;
  localparam int ACC_W  = 27;
  localparam int DIM_W  = 8;
  localparam int PE_LAT = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Identifies which kernel row of which output pixel a PE result belongs to.
  typedef struct packed {
    logic [1:0]       k;
    logic [DIM_W-1:0] ox;
    logic [DIM_W-1:0] oy;
  } beat_tag_t;

  function automatic logic signed [ACC_W-1:0] sext_psum(input logic signed [PSUM_W-1:0] p);
    return {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
  endfunction

endpackage

// File: rtl/pe_row_sched_if.sv
// Control, row-read request and result signals between the scheduler and its environment.
interface pe_row_sched_if;
  import conv_pkg::*;

  logic                     start;
  logic [DIM_W-1:0]         cfg_w;
  logic [DIM_W-1:0]         cfg_h;
  logic                     busy;
  logic                     done;
  logic                     rd_en;
  logic [DIM_W-1:0]         rd_row;
  logic [DIM_W-1:0]         rd_col;
  logic [1:0]               wgt_row_sel;
  logic                     rd_valid;
  logic signed [PSUM_W-1:0] pe_psum;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_valid;
  logic [DIM_W-1:0]         out_row;
  logic [DIM_W-1:0]         out_col;

  // master: the scheduler, which issues row reads and produces results
  modport master (
    input  start, cfg_w, cfg_h, rd_valid, pe_psum,
    output busy, done, rd_en, rd_row, rd_col, wgt_row_sel,
           out_data, out_valid, out_row, out_col
  );

  // slave: row buffer, PE and pass controller around the scheduler
  modport slave (
    output start, cfg_w, cfg_h, rd_valid, pe_psum,
    input  busy, done, rd_en, rd_row, rd_col, wgt_row_sel,
           out_data, out_valid, out_row, out_col
  );

endinterface

// File: rtl/pe_tag_pipe.sv
// Delay line carrying each accepted beat's tag alongside the PE pipeline.
module pe_tag_pipe
  import conv_pkg::*;
#(
  parameter int PE_LAT = conv_pkg::PE_LAT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  input  beat_tag_t in_tag,
  output logic      out_valid,
  output beat_tag_t out_tag,
  output logic      empty
);

  logic [PE_LAT-1:0] vld;
  beat_tag_t         tag [PE_LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < PE_LAT; i++) vld[i] <= vld[i-1];
    end
  end

  // NOTE: tag payload storage is left unreset; it is only ever read when its valid bit is set.
  always_ff @(posedge clk) begin
    tag[0] <= in_tag;
    for (int i = 1; i < PE_LAT; i++) tag[i] <= tag[i-1];
  end

  assign out_valid = vld[PE_LAT-1];
  assign out_tag   = tag[PE_LAT-1];
  assign empty     = ~|vld;

endmodule

// File: rtl/pe_row_sched.sv
// Sequences 3-beat row reads per output pixel for a 3x3 convolution and accumulates PE partial sums.
module pe_row_sched
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  pe_row_sched_if.master bus
);

  state_t state, state_nx;

  logic [DIM_W-1:0] ox_last, oy_last;
  logic [DIM_W-1:0] ox, oy;
  logic [1:0]       k;

  logic accept, last_beat, cfg_ok, start_ok;
  logic busy, done, rd_en;

  logic      tag_valid, pipe_empty;
  beat_tag_t tag_out;

  logic signed [ACC_W-1:0] acc, psum_ext;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_valid;
  logic [DIM_W-1:0]        out_row, out_col;

  assign accept    = rd_en && bus.rd_valid;
  assign last_beat = (k == 2'd2) && (ox == ox_last) && (oy == oy_last);
  assign cfg_ok    = (bus.cfg_w >= DIM_W'(3)) && (bus.cfg_h >= DIM_W'(3));
  assign start_ok  = (state == S_IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nx = cfg_ok ? S_RUN : S_DONE;
      end
      S_RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (accept && last_beat) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Last tag has left the pipe; its result is on out_data this cycle.
        if (pipe_empty) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Beat counter: k fastest, then ox, then oy; advances only on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_last <= '0;
      oy_last <= '0;
      ox      <= '0;
      oy      <= '0;
      k       <= '0;
    end else if (start_ok && cfg_ok) begin
      ox_last <= bus.cfg_w - DIM_W'(3);
      oy_last <= bus.cfg_h - DIM_W'(3);
      ox      <= '0;
      oy      <= '0;
      k       <= '0;
    end else if (accept) begin
      if (last_beat) begin
        ox <= '0;
        oy <= '0;
        k  <= '0;
      end else if (k != 2'd2) begin
        k <= k + 2'd1;
      end else begin
        k <= '0;
        if (ox == ox_last) begin
          ox <= '0;
          oy <= oy + DIM_W'(1);
        end else begin
          ox <= ox + DIM_W'(1);
        end
      end
    end
  end

  pe_tag_pipe #(.PE_LAT(PE_LAT)) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_tag    ('{k: k, ox: ox, oy: oy}),
    .out_valid (tag_valid),
    .out_tag   (tag_out),
    .empty     (pipe_empty)
  );

  assign psum_ext = sext_psum(bus.pe_psum);

  // pe_psum is only consumed when a tag emerges, so bubble-cycle garbage never reaches acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (tag_valid) begin
        unique case (tag_out.k)
          2'd0: acc <= psum_ext;
          2'd1: acc <= acc + psum_ext;
          2'd2: begin
            out_data  <= acc + psum_ext;
            out_valid <= 1'b1;
            out_row   <= tag_out.oy;
            out_col   <= tag_out.ox;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.rd_en       = rd_en;
  assign bus.rd_row      = oy + DIM_W'(k);
  assign bus.rd_col      = ox;
  assign bus.wgt_row_sel = k;
  assign bus.out_data    = out_data;
  assign bus.out_valid   = out_valid;
  assign bus.out_row     = out_row;
  assign bus.out_col     = out_col;

endmodule

// File: tb/tb_pe_row_sched.sv
// Self-checking bench: per-cycle comparison of pe_row_sched against a beat/pixel-list reference model.
module tb_pe_row_sched;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pe_row_sched_if bus ();

  pe_row_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { int row; int col; int k; int ox; int oy; } beat_t;
  typedef struct { int cyc; int row; int col; logic [26:0] sum; } out_t;
  typedef struct { int cyc; logic [24:0] val; } psum_t;

  beat_t       beats [$];
  logic [24:0] psums [$];
  out_t        outs  [$];
  psum_t       sched [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      {31'd0, bus.busy},        32'd0);
    check({tag, "_done"},      {31'd0, bus.done},        32'd0);
    check({tag, "_rd_en"},     {31'd0, bus.rd_en},       32'd0);
    check({tag, "_rd_row"},    {24'd0, bus.rd_row},      32'd0);
    check({tag, "_rd_col"},    {24'd0, bus.rd_col},      32'd0);
    check({tag, "_wgt_sel"},   {30'd0, bus.wgt_row_sel}, 32'd0);
    check({tag, "_out_data"},  {5'd0, bus.out_data},     32'd0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid},   32'd0);
    check({tag, "_out_row"},   {24'd0, bus.out_row},     32'd0);
    check({tag, "_out_col"},   {24'd0, bus.out_col},     32'd0);
  endtask

  // vmode: 0 rd_valid always high, 1 random, 2 two-cycle bubble after the first beat.
  // pmode: 0 psums from p0/p1/p2 by kernel row, 1 random psums.
  task automatic run_pass(input int w, input int h, input int vmode, input int pmode,
                          input logic [24:0] p0, input logic [24:0] p1, input logic [24:0] p2,
                          input bit glitch, input int abort_at);
    int     nbeats, idx, done_cyc, bub, budget;
    bit     finished, exp_en, exp_ov;
    longint s;
    beats.delete(); psums.delete(); outs.delete(); sched.delete();
    if (w >= 3 && h >= 3) begin
      for (int oy = 0; oy <= h - 3; oy++)
        for (int ox = 0; ox <= w - 3; ox++)
          for (int k = 0; k < 3; k++) begin
            beats.push_back('{row: oy + k, col: ox, k: k, ox: ox, oy: oy});
            if (pmode == 1) psums.push_back(25'($urandom));
            else            psums.push_back(k == 0 ? p0 : (k == 1 ? p1 : p2));
          end
    end
    nbeats   = beats.size();
    idx      = 0;
    bub      = 0;
    finished = 1'b0;
    done_cyc = (nbeats == 0) ? 1 : -1;
    budget   = nbeats * 6 + 40;

    @(negedge clk);
    bus.start    = 1'b1;
    bus.cfg_w    = 8'(w);
    bus.cfg_h    = 8'(h);
    bus.rd_valid = 1'b0;
    bus.pe_psum  = 25'($urandom);

    for (int n = 1; n <= budget && !finished; n++) begin
      @(negedge clk);
      exp_en = (idx < nbeats);
      check("rd_en", {31'd0, bus.rd_en}, {31'd0, exp_en});
      if (exp_en) begin
        check("rd_row",  {24'd0, bus.rd_row},      32'(beats[idx].row));
        check("rd_col",  {24'd0, bus.rd_col},      32'(beats[idx].col));
        check("wgt_sel", {30'd0, bus.wgt_row_sel}, 32'(beats[idx].k));
      end
      exp_ov = (outs.size() > 0) && (outs[0].cyc == n);
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      if (exp_ov) begin
        check("out_data", {5'd0, bus.out_data}, {5'd0, outs[0].sum});
        check("out_row",  {24'd0, bus.out_row}, 32'(outs[0].row));
        check("out_col",  {24'd0, bus.out_col}, 32'(outs[0].col));
        void'(outs.pop_front());
      end
      check("done", {31'd0, bus.done}, {31'd0, (n == done_cyc)});
      if (n != done_cyc) check("busy", {31'd0, bus.busy}, 32'd1);
      if (abort_at != 0 && n == abort_at) return;
      if (n == done_cyc) finished = 1'b1;

      // Drive this cycle's inputs; cfg is garbage after start to prove it was latched.
      bus.start = (glitch && n == 3);
      bus.cfg_w = (glitch && n == 3) ? 8'd9 : 8'($urandom);
      bus.cfg_h = (glitch && n == 3) ? 8'd9 : 8'($urandom);
      if (vmode == 0)      bus.rd_valid = 1'b1;
      else if (vmode == 1) bus.rd_valid = ($urandom_range(0, 9) < 7);
      else if (idx == 1 && bub < 2) begin
        bus.rd_valid = 1'b0;
        bub++;
      end else bus.rd_valid = 1'b1;
      if (sched.size() > 0 && sched[0].cyc == n) begin
        bus.pe_psum = sched[0].val;
        void'(sched.pop_front());
      end else begin
        bus.pe_psum = 25'($urandom);
      end

      // Reference model: an accepted beat's psum is due 3 cycles later, its pixel result 4 later.
      if (exp_en && bus.rd_valid) begin
        sched.push_back('{cyc: n + 3, val: psums[idx]});
        if (beats[idx].k == 2) begin
          s = longint'($signed(psums[idx-2])) + longint'($signed(psums[idx-1]))
            + longint'($signed(psums[idx]));
          outs.push_back('{cyc: n + 4, row: beats[idx].oy, col: beats[idx].ox, sum: s[26:0]});
        end
        idx++;
        if (idx == nbeats) done_cyc = n + 5;
      end
    end

    check("pass_finished", {31'd0, finished}, 32'd1);
    bus.start    = 1'b0;
    bus.rd_valid = 1'b0;
    @(negedge clk);
    check("idle_busy",      {31'd0, bus.busy},      32'd0);
    check("idle_done",      {31'd0, bus.done},      32'd0);
    check("idle_rd_en",     {31'd0, bus.rd_en},     32'd0);
    check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.cfg_w    = '0;
    bus.cfg_h    = '0;
    bus.rd_valid = 1'b0;
    bus.pe_psum  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 3x3 single pixel: 10+20+30 = 60 at row 0, col 0.
    run_pass(3, 3, 0, 0, 25'd10, 25'd20, 25'd30, 1'b0, 0);
    // 5x4: six pixels of -100-200-300 = -600, one every 3 cycles.
    run_pass(5, 4, 0, 0, -25'sd100, -25'sd200, -25'sd300, 1'b0, 0);
    // Two-cycle rd_valid bubble mid-pixel with garbage pe_psum.
    run_pass(4, 3, 2, 1, 25'd0, 25'd0, 25'd0, 1'b0, 0);
    // Largest positive psum on every beat: 3 * 16777215 = 50331645.
    run_pass(3, 3, 0, 0, 25'd16777215, 25'd16777215, 25'd16777215, 1'b0, 0);
    // Degenerate sizes are empty passes.
    run_pass(2, 5, 0, 1, 25'd0, 25'd0, 25'd0, 1'b0, 0);
    run_pass(7, 2, 1, 1, 25'd0, 25'd0, 25'd0, 1'b0, 0);
    // Start asserted mid-RUN with a different cfg must be ignored.
    run_pass(4, 4, 0, 1, 25'd0, 25'd0, 25'd0, 1'b1, 0);
    // Random sizes, random rd_valid, random psums.
    for (int i = 0; i < 5; i++)
      run_pass($urandom_range(3, 7), $urandom_range(3, 6), 1, 1, 25'd0, 25'd0, 25'd0, 1'b0, 0);

    // Reset in the middle of a pass, then a clean pass afterwards.
    run_pass(5, 5, 0, 1, 25'd0, 25'd0, 25'd0, 1'b0, 7);
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.rd_valid = 1'b0;
    #1;
    check_all_zero("midpass_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pass(3, 4, 1, 1, 25'd0, 25'd0, 25'd0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
